// File: rtl/forward_ctrl.sv
// Hazard unit for a 5-stage pipeline: load-use stall detection plus registered
// EX-stage operand-forwarding selects, tracked through private EX/MEM/WB records.
module forward_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    logic             ex_valid;
    logic [REG_W-1:0] ex_dst;
    logic             ex_regwrite;
    logic             ex_memread;
    logic             mem_valid;
    logic [REG_W-1:0] mem_dst;
    logic             mem_regwrite;
    logic             wb_valid;
    logic [REG_W-1:0] wb_dst;
    logic             wb_regwrite;

    logic       ex_writes;
    logic       mem_writes;
    logic       bubble;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    // Register 0 is hardwired, so a producer targeting it never forwards or stalls.
    always_comb begin
        ex_writes  = ex_valid & ex_regwrite & (ex_dst != '0);
        mem_writes = mem_valid & mem_regwrite & (mem_dst != '0);
        stall      = ~rst & id_valid & ex_writes & ex_memread &
                     ((ex_dst == id_rs) | (ex_dst == id_rt));
        bubble     = stall | flush | ~id_valid;

        sel_a = SEL_RF;
        if (ex_writes && ex_dst == id_rs) begin
            sel_a = SEL_MEM;
        end else if (mem_writes && mem_dst == id_rs) begin
            sel_a = SEL_WB;
        end

        sel_b = SEL_RF;
        if (ex_writes && ex_dst == id_rt) begin
            sel_b = SEL_MEM;
        end else if (mem_writes && mem_dst == id_rt) begin
            sel_b = SEL_WB;
        end
    end

    // EX compares against the records that are about to become MEM and WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_dst       <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_valid    <= 1'b0;
            mem_dst      <= '0;
            mem_regwrite <= 1'b0;
            wb_valid     <= 1'b0;
            wb_dst       <= '0;
            wb_regwrite  <= 1'b0;
            fwd_a        <= SEL_RF;
            fwd_b        <= SEL_RF;
            stall_count  <= '0;
        end else begin
            mem_valid    <= ex_valid;
            mem_dst      <= ex_dst;
            mem_regwrite <= ex_regwrite;
            wb_valid     <= mem_valid;
            wb_dst       <= mem_dst;
            wb_regwrite  <= mem_regwrite;

            if (bubble) begin
                ex_valid    <= 1'b0;
                ex_dst      <= '0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                fwd_a       <= SEL_RF;
                fwd_b       <= SEL_RF;
            end else begin
                ex_valid    <= 1'b1;
                ex_dst      <= id_dst;
                ex_regwrite <= id_regwrite;
                ex_memread  <= id_memread;
                fwd_a       <= sel_a;
                fwd_b       <= sel_b;
            end

            if (stall && stall_count != '1) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_forward_ctrl.sv
// Randomized + directed bench for forward_ctrl; a pipeline-history reference
// model feeds a scoreboard queue that a separate monitor drains and compares.
module tb_forward_ctrl;

    localparam int REG_W   = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_dst;
    logic             id_regwrite;
    logic             id_memread;
    logic             flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             stall;
    logic [CNT_W-1:0] stall_count;

    forward_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit             valid;
        bit [REG_W-1:0] dst;
        bit             rw;
        bit             mr;
    } instr_t;

    typedef struct {
        bit       stall;
        int       fa;
        int       fb;
        int       cnt;
    } exp_t;

    // history[0] = instruction that entered EX most recently, history[1] = one before.
    instr_t history[$];
    exp_t   sb[$];
    int     model_cnt;
    int     errors = 0;
    int     checks = 0;

    function automatic bit produces(instr_t p, bit [REG_W-1:0] src);
        return p.valid && p.rw && p.dst != 0 && p.dst == src;
    endfunction

    function automatic int pick(instr_t in_mem, instr_t in_wb, bit [REG_W-1:0] src);
        if (produces(in_mem, src)) return 1;
        if (produces(in_wb, src))  return 2;
        return 0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit v, input int rs, input int rt,
                                 input int dst, input bit rw, input bit mr, input bit fl);
        exp_t   e;
        instr_t nxt;
        instr_t bub;
        bit     uses;
        @(negedge clk);
        rst = r; id_valid = v; id_rs = REG_W'(rs); id_rt = REG_W'(rt);
        id_dst = REG_W'(dst); id_regwrite = rw; id_memread = mr; flush = fl;

        bub  = '{valid: 0, dst: 0, rw: 0, mr: 0};
        uses = (history[0].dst == REG_W'(rs)) || (history[0].dst == REG_W'(rt));
        e.stall = !r && v && history[0].mr && produces(history[0], history[0].dst) && uses;
        if (r) begin
            e.fa = 0; e.fb = 0; model_cnt = 0;
            history = '{bub, bub};
        end else begin
            if (e.stall || fl || !v) begin
                e.fa = 0; e.fb = 0; nxt = bub;
            end else begin
                e.fa = pick(history[0], history[1], REG_W'(rs));
                e.fb = pick(history[0], history[1], REG_W'(rt));
                nxt  = '{valid: 1, dst: REG_W'(dst), rw: rw, mr: mr};
            end
            if (e.stall && model_cnt < CNT_MAX) model_cnt++;
            history.push_front(nxt);
            void'(history.pop_back());
        end
        e.cnt = model_cnt;
        sb.push_back(e);
    endtask

    // Monitor: stall is judged mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() == 0) continue;
            e = sb.pop_front();
            checkOutput("stall", int'(stall), int'(e.stall));
            @(posedge clk);
            #1;
            checkOutput("fwd_a", int'(fwd_a), e.fa);
            checkOutput("fwd_b", int'(fwd_b), e.fb);
            checkOutput("stall_count", int'(stall_count), e.cnt);
        end
    end

    initial begin
        instr_t bub;
        bub = '{valid: 0, dst: 0, rw: 0, mr: 0};
        history = '{bub, bub};
        model_cnt = 0;
        rst = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_dst = 0;
        id_regwrite = 0; id_memread = 0; flush = 0;

        //            rst v  rs rt dst rw mr fl
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 5, 5, 5, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // back-to-back producer/consumer: MEM forward on operand A
        applyStimulus(0, 1, 1, 2, 5, 1, 0, 0);
        applyStimulus(0, 1, 5, 9, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // WB forward with a gap, then MEM winning over WB
        applyStimulus(0, 1, 1, 2, 5, 1, 0, 0);
        applyStimulus(0, 1, 1, 2, 6, 1, 0, 0);
        applyStimulus(0, 1, 3, 5, 8, 1, 0, 0);
        applyStimulus(0, 1, 1, 2, 5, 1, 0, 0);
        applyStimulus(0, 1, 1, 2, 5, 1, 0, 0);
        applyStimulus(0, 1, 5, 5, 9, 1, 0, 0);

        // load-use: one stall, consumer re-presented
        applyStimulus(0, 1, 1, 2, 7, 1, 1, 0);
        applyStimulus(0, 1, 7, 2, 9, 1, 0, 0);
        applyStimulus(0, 1, 7, 2, 9, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // register 0 never forwards
        applyStimulus(0, 1, 1, 2, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 4, 1, 0, 0);

        // flushed load produces neither stall nor forward
        applyStimulus(0, 1, 1, 2, 3, 1, 1, 1);
        applyStimulus(0, 1, 3, 2, 9, 1, 0, 0);
        applyStimulus(0, 1, 1, 2, 9, 1, 1, 0);
        applyStimulus(0, 1, 9, 9, 4, 1, 0, 1);

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(99) < 2, $urandom_range(99) < 85,
                          $urandom_range(7), $urandom_range(7), $urandom_range(7),
                          $urandom_range(99) < 70, $urandom_range(99) < 30,
                          $urandom_range(99) < 10);
        end

        // drive the counter into saturation with repeated load-use pairs
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            applyStimulus(0, 1, 1, 2, 4, 1, 1, 0);
            applyStimulus(0, 1, 4, 1, 6, 1, 0, 0);
            applyStimulus(0, 1, 4, 1, 6, 1, 0, 0);
        end
        applyStimulus(0, 1, 1, 2, 4, 1, 1, 0);
        applyStimulus(1, 1, 4, 4, 6, 1, 0, 0);
        applyStimulus(0, 1, 4, 4, 6, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
